q_pipe_scheduler: RTL and testbench

//  Issue controller for the q = ((a-b)*(3c+1) - 4d) >>> 1 pipeline.

---
 rtl/q_pipe_scheduler.sv | 129 ++++++++++++
 tb/tb_q_pipe_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/q_pipe_scheduler.sv
// rtl/q_pipe_scheduler.sv - operand collector, issue control and credit-guarded result FIFO
// for the q = ((a-b)*(3c+1) - 4d) >>> 1 datapath.
module q_pipe_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         artsn_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [DATA_WIDTH-1:0] c_i,
  input  logic signed [DATA_WIDTH-1:0] d_i,
  input  logic                         a_valid_i,
  input  logic                         b_valid_i,
  input  logic                         c_valid_i,
  input  logic                         d_valid_i,
  output logic                         a_ready_o,
  output logic                         b_ready_o,
  output logic                         c_ready_o,
  output logic                         d_ready_o,
  output logic signed [DATA_WIDTH-1:0] dp_a_o,
  output logic signed [DATA_WIDTH-1:0] dp_b_o,
  output logic signed [DATA_WIDTH-1:0] dp_c_o,
  output logic signed [DATA_WIDTH-1:0] dp_d_o,
  output logic                         dp_valid_o,
  input  logic signed [DATA_WIDTH-1:0] dp_q_i,
  input  logic                         dp_q_valid_i,
  output logic signed [DATA_WIDTH-1:0] q_o,
  output logic                         q_valid_o,
  input  logic                         q_ready_i,
  output logic                         err_o,
  output logic [2:0]                   state_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_IDLE_BUSY = 3'd1,
    S_COLLECT   = 3'd2,
    S_READY     = 3'd3,
    S_STALL     = 3'd4
  } state_t;

  state_t                 state;
  logic                   run;
  logic [3:0]             held, held_nxt, in_valid, ready, acc;
  logic signed [DATA_WIDTH-1:0] in_data [4];
  logic signed [DATA_WIDTH-1:0] hold    [4];
  logic signed [DATA_WIDTH-1:0] mem     [FIFO_DEPTH];
  logic [CW-1:0]          outstanding, outstanding_nxt, count, count_nxt, inflight;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   issue_fire, pop, push;

  assign in_valid   = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};
  assign in_data[0] = a_i;
  assign in_data[1] = b_i;
  assign in_data[2] = c_i;
  assign in_data[3] = d_i;

  // Credit check uses the registered count, so a pop never frees a slot in the same cycle.
  assign issue_fire = (&held) & (outstanding < DEPTH_C);
  assign ready      = run ? (~held | {4{issue_fire}}) : 4'b0000;
  assign acc        = in_valid & ready;
  assign held_nxt   = acc | (held & ~{4{issue_fire}});

  assign {d_ready_o, c_ready_o, b_ready_o, a_ready_o} = ready;
  assign dp_a_o     = hold[0];
  assign dp_b_o     = hold[1];
  assign dp_c_o     = hold[2];
  assign dp_d_o     = hold[3];
  assign dp_valid_o = issue_fire;

  assign pop             = q_valid_o & q_ready_i;
  assign inflight        = outstanding - count;
  assign push            = dp_q_valid_i & (inflight != '0);
  assign outstanding_nxt = outstanding + CW'(issue_fire) - CW'(pop);
  assign count_nxt       = count + CW'(push) - CW'(pop);
  assign q_o             = q_valid_o ? mem[rd_ptr] : '0;
  assign state_o         = state;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_C) ? '0 : p + AW'(1);
  endfunction

  function automatic state_t state_of(input logic [3:0] h, input logic [CW-1:0] o);
    if (&h)           return (o < DEPTH_C) ? S_READY : S_STALL;
    else if (|h)      return S_COLLECT;
    else if (o != '0) return S_IDLE_BUSY;
    else              return S_IDLE;
  endfunction

  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      run         <= 1'b0;
      held        <= '0;
      for (int i = 0; i < 4; i++) hold[i] <= '0;
      outstanding <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_valid_o   <= 1'b0;
      err_o       <= 1'b0;
      state       <= S_IDLE;
    end else begin
      run  <= 1'b1;
      held <= held_nxt;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) hold[i] <= in_data[i];
      end
      outstanding <= outstanding_nxt;
      count       <= count_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      q_valid_o <= (count_nxt != '0);
      // A result with nothing in flight is dropped and flagged.
      if (dp_q_valid_i && (inflight == '0)) err_o <= 1'b1;
      state <= state_of(held_nxt, outstanding_nxt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= dp_q_i;
  end

endmodule

// File: tb/tb_q_pipe_scheduler.sv
// tb/tb_q_pipe_scheduler.sv - directed bench for q_pipe_scheduler with a 3-stage datapath stand-in.
module tb_q_pipe_scheduler;

  localparam int S_IDLE = 0, S_COLLECT = 2, S_READY = 3, S_STALL = 4;

  logic clk, artsn;
  logic signed [15:0] op_a, op_b, op_c, op_d;
  logic a_vld, b_vld, c_vld, d_vld;
  logic a_rdy, b_rdy, c_rdy, d_rdy;
  logic signed [15:0] dp_a, dp_b, dp_c, dp_d, dp_q, q;
  logic dp_valid, dp_q_valid, q_valid, q_ready, err, spur;
  logic [2:0] state;

  int checks = 0, errors = 0;
  int sa[8], sb[8], sc[8], sd[8];
  int nsets, n_issue;
  int idx[4];
  bit pend[4];

  q_pipe_scheduler #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .artsn_i(artsn),
    .a_i(op_a), .b_i(op_b), .c_i(op_c), .d_i(op_d),
    .a_valid_i(a_vld), .b_valid_i(b_vld), .c_valid_i(c_vld), .d_valid_i(d_vld),
    .a_ready_o(a_rdy), .b_ready_o(b_rdy), .c_ready_o(c_rdy), .d_ready_o(d_rdy),
    .dp_a_o(dp_a), .dp_b_o(dp_b), .dp_c_o(dp_c), .dp_d_o(dp_d), .dp_valid_o(dp_valid),
    .dp_q_i(dp_q), .dp_q_valid_i(dp_q_valid),
    .q_o(q), .q_valid_o(q_valid), .q_ready_i(q_ready),
    .err_o(err), .state_o(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [15:0] dp_fn(input logic signed [15:0] a, b, c, d);
    int t;
    t = (int'(a) - int'(b)) * (3 * int'(c) + 1) - 4 * int'(d);
    return 16'(t >>> 1);
  endfunction

  // Fixed-latency (3) datapath sharing the reset.
  logic [2:0] pv;
  logic signed [15:0] pq [3];
  always @(posedge clk or negedge artsn) begin
    if (!artsn) begin
      pv <= '0;
      for (int i = 0; i < 3; i++) pq[i] <= '0;
    end else begin
      pv    <= {pv[1:0], dp_valid};
      pq[0] <= dp_fn(dp_a, dp_b, dp_c, dp_d);
      pq[1] <= pq[0];
      pq[2] <= pq[1];
    end
  end
  assign dp_q_valid = pv[2] | spur;
  assign dp_q       = spur ? 16'sd99 : pq[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_valids();
    a_vld = 0; b_vld = 0; c_vld = 0; d_vld = 0;
  endtask

  task automatic send_set(input int a, input int b, input int c, input int d);
    @(negedge clk);
    op_a = 16'(a); op_b = 16'(b); op_c = 16'(c); op_d = 16'(d);
    a_vld = 1; b_vld = 1; c_vld = 1; d_vld = 1;
    @(negedge clk);
    clear_valids();
  endtask

  task automatic pop_expect(input string tag, input int exp);
    int n = 0;
    while (!q_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!q_valid) check_eq({tag, "_timeout"}, 0, 1);
    else begin
      check_eq(tag, 32'(q), 32'(16'(exp)));
      q_ready = 1;
      @(negedge clk);
      q_ready = 0;
    end
  endtask

  task automatic stream_reset();
    for (int ch = 0; ch < 4; ch++) begin idx[ch] = 0; pend[ch] = 0; end
    n_issue = 0;
  endtask

  task automatic drive_step();
    @(negedge clk);
    if (dp_valid) n_issue++;
    for (int ch = 0; ch < 4; ch++) if (pend[ch]) idx[ch]++;
    a_vld = idx[0] < nsets; if (a_vld) op_a = 16'(sa[idx[0]]);
    b_vld = idx[1] < nsets; if (b_vld) op_b = 16'(sb[idx[1]]);
    c_vld = idx[2] < nsets; if (c_vld) op_c = 16'(sc[idx[2]]);
    d_vld = idx[3] < nsets; if (d_vld) op_d = 16'(sd[idx[3]]);
    pend[0] = a_vld & a_rdy; pend[1] = b_vld & b_rdy;
    pend[2] = c_vld & c_rdy; pend[3] = d_vld & d_rdy;
  endtask

  initial begin
    int popped, issues, n;
    artsn = 0; spur = 0; q_ready = 0;
    op_a = 0; op_b = 0; op_c = 0; op_d = 0;
    clear_valids();
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {d_rdy, c_rdy, b_rdy, a_rdy}, 0);
    check_eq("rst_qvalid", q_valid, 0);
    check_eq("rst_dpvalid", dp_valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_state", state, S_IDLE);
    check_eq("rst_q", 32'(q), 0);
    artsn = 1;
    @(negedge clk);
    check_eq("idle_ready", {d_rdy, c_rdy, b_rdy, a_rdy}, 4'b1111);

    // 1: single set, latency to q_valid is 2+L
    send_set(10, 4, 2, 3);
    check_eq("t1_dpvalid", dp_valid, 1);
    check_eq("t1_dp_ops", {dp_a, dp_b, dp_c, dp_d}, 64'h000a_0004_0002_0003);
    check_eq("t1_state", state, S_READY);
    @(negedge clk);
    check_eq("t1_pulse", dp_valid, 0);
    repeat (2) @(negedge clk);
    check_eq("t1_qvalid_early", q_valid, 0);
    @(negedge clk);
    check_eq("t1_qvalid", q_valid, 1);
    pop_expect("t1_q", 15);
    check_eq("t1_empty", q_valid, 0);

    // 2: signed operands
    send_set(-5, 3, -1, 1);
    pop_expect("t2_q", 6);

    // 3: staggered arrival, a second a held high behind the first
    issues = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      if (dp_valid) begin
        issues++;
        check_eq("t3_issue_cyc", cyc, 6);
        check_eq("t3_dp_a", 32'(dp_a), 7);
      end
      if (cyc >= 1 && cyc <= 5) check_eq($sformatf("t3_a_ready_c%0d", cyc), a_rdy, 0);
      if (cyc == 6) check_eq("t3_a_ready_c6", a_rdy, 1);
      a_vld = (cyc <= 6); op_a = (cyc == 0) ? 16'sd7 : 16'sd3;
      b_vld = (cyc == 2); op_b = 16'sd2;
      c_vld = (cyc == 2); op_c = 16'sd1;
      d_vld = (cyc == 5); op_d = 16'sd1;
    end
    check_eq("t3_issues", issues, 1);
    check_eq("t3_state", state, S_COLLECT);
    @(negedge clk);
    op_b = 1; op_c = 0; op_d = 0;
    b_vld = 1; c_vld = 1; d_vld = 1;
    @(negedge clk);
    clear_valids();
    check_eq("t3_second_issue", dp_valid, 1);
    check_eq("t3_second_a", 32'(dp_a), 3);
    pop_expect("t3_q0", 8);
    pop_expect("t3_q1", 1);

    // 4: backpressure with 8 back-to-back sets
    nsets = 8;
    for (int k = 0; k < 8; k++) begin sa[k] = 2 * (k + 1); sb[k] = 0; sc[k] = 0; sd[k] = 0; end
    stream_reset();
    repeat (20) drive_step();
    check_eq("t4_issues_stalled", n_issue, 4);
    check_eq("t4_state", state, S_STALL);
    check_eq("t4_ready", {d_rdy, c_rdy, b_rdy, a_rdy}, 0);
    check_eq("t4_qvalid", q_valid, 1);
    q_ready = 1;
    check_eq("t4_no_issue_on_pop", dp_valid, 0);
    popped = 0;
    for (int cyc = 0; cyc < 60 && popped < 8; cyc++) begin
      if (q_valid) begin
        check_eq($sformatf("t4_q%0d", popped), 32'(q), popped + 1);
        popped++;
      end
      drive_step();
    end
    q_ready = 0;
    check_eq("t4_popped", popped, 8);
    check_eq("t4_issues", n_issue, 8);
    repeat (2) @(negedge clk);
    check_eq("t4_drained", q_valid, 0);

    // 5: spurious datapath result
    check_eq("t5_err_before", err, 0);
    @(negedge clk);
    spur = 1;
    @(negedge clk);
    spur = 0;
    check_eq("t5_err", err, 1);
    check_eq("t5_qvalid", q_valid, 0);
    repeat (3) @(negedge clk);
    check_eq("t5_err_sticky", err, 1);
    check_eq("t5_qvalid_later", q_valid, 0);
    check_eq("t5_state", state, S_IDLE);

    // 6: reset with 1 result queued and 2 in flight
    nsets = 3;
    for (int k = 0; k < 3; k++) begin sa[k] = 2 * (k + 1); sb[k] = 0; sc[k] = 0; sd[k] = 0; end
    stream_reset();
    n = 0;
    while (!q_valid && n < 20) begin drive_step(); n++; end
    check_eq("t6_fifo1", q_valid, 1);
    check_eq("t6_issues", n_issue, 3);
    check_eq("t6_inflight", pv[2:1], 2'b11);
    artsn = 0;
    clear_valids();
    #1;
    check_eq("t6_rst_qvalid", q_valid, 0);
    check_eq("t6_rst_q", 32'(q), 0);
    check_eq("t6_rst_ready", {d_rdy, c_rdy, b_rdy, a_rdy}, 0);
    check_eq("t6_rst_dpvalid", dp_valid, 0);
    check_eq("t6_rst_dp_ops", {dp_a, dp_b, dp_c, dp_d}, 0);
    check_eq("t6_rst_err", err, 0);
    check_eq("t6_rst_state", state, S_IDLE);
    repeat (2) @(negedge clk);
    artsn = 1;
    @(negedge clk);
    check_eq("t6_ready_after", {d_rdy, c_rdy, b_rdy, a_rdy}, 4'b1111);
    send_set(1, 0, 0, 0);
    pop_expect("t6_q", 0);
    repeat (5) @(negedge clk);
    check_eq("t6_no_stale", q_valid, 0);
    check_eq("t6_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
